// File: rtl/lsd_multi_line_buffer_pkg.sv
// Shared types and helpers for the multi-channel LSD segment buffer.
// A segment is packed as {start_v, start_h, end_v, end_h}, start_v in the MSBs.
package lsd_multi_line_buffer_pkg;

  localparam int unsigned HBitwDef = 10;
  localparam int unsigned VBitwDef = 9;

  typedef struct packed {
    logic [VBitwDef-1:0] start_v;
    logic [HBitwDef-1:0] start_h;
    logic [VBitwDef-1:0] end_v;
    logic [HBitwDef-1:0] end_h;
  } lsd_seg_t;

  function automatic int unsigned seg_width(int unsigned h_bitw, int unsigned v_bitw);
    return 2 * (h_bitw + v_bitw);
  endfunction

endpackage

// File: rtl/lsd_multi_line_buffer_bank.sv
// One channel of the line buffer: ping-pong segment storage, write counter, PS frame lock,
// overflow tracking and a saturating dropped-frame counter. Read port is registered.
module lsd_multi_line_buffer_bank
  import lsd_multi_line_buffer_pkg::*;
#(
  parameter int unsigned H_BITW    = HBitwDef,
  parameter int unsigned V_BITW    = VBitwDef,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned DROP_BITW = 8,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned SegW     = seg_width(H_BITW, V_BITW)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 in_flag,
  input  logic                 in_valid,
  input  logic [SegW-1:0]      in_seg,
  input  logic                 rel,
  input  logic [AW-1:0]        rd_addr,
  output logic                 ready,
  output logic [AW:0]          line_num,
  output logic                 overflow,
  output logic [DROP_BITW-1:0] drop_cnt,
  output logic                 rd_valid,
  output logic [SegW-1:0]      rd_data
);

  logic [SegW-1:0] mem [2*DEPTH];

  logic                 wbank_q, wbank_d;
  logic [AW:0]          wcnt_q, wcnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 ready_q, ready_d;
  logic [AW:0]          line_num_q, line_num_d;
  logic                 overflow_q, overflow_d;
  logic [DROP_BITW-1:0] drop_cnt_q, drop_cnt_d;
  logic                 rd_valid_q;
  logic [SegW-1:0]      rd_data_q;

  logic        full;
  logic        wr_en;
  logic        ovf_next;
  logic [AW:0] final_cnt;

  // DEPTH is a power of two, so the counter MSB alone marks a full bank.
  assign full      = wcnt_q[AW];
  assign wr_en     = in_valid & ~full;
  assign final_cnt = wcnt_q + (AW+1)'(wr_en);
  assign ovf_next  = ovf_pend_q | (in_valid & full);

  always_comb begin
    wbank_d    = wbank_q;
    wcnt_d     = final_cnt;
    ovf_pend_d = ovf_next;
    ready_d    = ready_q;
    line_num_d = line_num_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (rel) begin
      ready_d = 1'b0;
    end
    if (in_flag) begin
      wcnt_d     = '0;
      ovf_pend_d = 1'b0;
      // A release in the same cycle unlocks first, so the new frame can swap in.
      if (!(ready_q && !rel)) begin
        wbank_d    = ~wbank_q;
        line_num_d = final_cnt;
        overflow_d = ovf_next;
        ready_d    = 1'b1;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_BITW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wbank_q    <= 1'b0;
      wcnt_q     <= '0;
      ovf_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      line_num_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wbank_q    <= wbank_d;
      wcnt_q     <= wcnt_d;
      ovf_pend_q <= ovf_pend_d;
      ready_q    <= ready_d;
      line_num_q <= line_num_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= ready_q && ({1'b0, rd_addr} < line_num_q);
    end
  end

  // Storage has no reset; stale contents are masked by rd_valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[{wbank_q, wcnt_q[AW-1:0]}] <= in_seg;
    end
    rd_data_q <= mem[{~wbank_q, rd_addr}];
  end

  assign ready    = ready_q;
  assign line_num = line_num_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/lsd_multi_line_buffer.sv
// Multi-channel LSD segment buffer: one ping-pong bank per channel plus a shared registered
// read port selected by rd_ch, with per-channel frame lock/release toward the PS.
module lsd_multi_line_buffer
  import lsd_multi_line_buffer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned H_BITW    = HBitwDef,
  parameter int unsigned V_BITW    = VBitwDef,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned DROP_BITW = 8,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned RCW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           in_flag,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*V_BITW-1:0]    in_start_v,
  input  logic [NUM_CH*H_BITW-1:0]    in_start_h,
  input  logic [NUM_CH*V_BITW-1:0]    in_end_v,
  input  logic [NUM_CH*H_BITW-1:0]    in_end_h,
  input  logic [RCW-1:0]              rd_ch,
  input  logic [AW-1:0]               rd_addr,
  input  logic                        rd_release,
  output logic [NUM_CH-1:0]           out_ready,
  output logic [NUM_CH*(AW+1)-1:0]    out_line_num,
  output logic [NUM_CH-1:0]           out_overflow,
  output logic [NUM_CH*DROP_BITW-1:0] out_drop_cnt,
  output logic [V_BITW-1:0]           out_start_v,
  output logic [H_BITW-1:0]           out_start_h,
  output logic [V_BITW-1:0]           out_end_v,
  output logic [H_BITW-1:0]           out_end_h
);

  localparam int unsigned SegW = seg_width(H_BITW, V_BITW);

  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] rd_valid;
  logic [SegW-1:0]   rd_data [NUM_CH];
  logic [RCW-1:0]    rd_ch_q;

  always_comb begin
    rel = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      rel[c] = rd_release && (rd_ch == RCW'(c));
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    lsd_multi_line_buffer_bank #(
      .H_BITW   (H_BITW),
      .V_BITW   (V_BITW),
      .DEPTH    (DEPTH),
      .DROP_BITW(DROP_BITW)
    ) u_bank (
      .clock   (clock),
      .rst     (rst),
      .in_flag (in_flag[g]),
      .in_valid(in_valid[g]),
      .in_seg  ({in_start_v[g*V_BITW +: V_BITW], in_start_h[g*H_BITW +: H_BITW],
                 in_end_v[g*V_BITW +: V_BITW], in_end_h[g*H_BITW +: H_BITW]}),
      .rel     (rel[g]),
      .rd_addr (rd_addr),
      .ready   (out_ready[g]),
      .line_num(out_line_num[g*(AW+1) +: (AW+1)]),
      .overflow(out_overflow[g]),
      .drop_cnt(out_drop_cnt[g*DROP_BITW +: DROP_BITW]),
      .rd_valid(rd_valid[g]),
      .rd_data (rd_data[g])
    );
  end

  // Channel select is registered alongside the bank read so the mux lines up with the data.
  always_ff @(posedge clock) begin
    if (rst) begin
      rd_ch_q <= '0;
    end else begin
      rd_ch_q <= rd_ch;
    end
  end

  always_comb begin
    {out_start_v, out_start_h, out_end_v, out_end_h} = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (rd_ch_q == RCW'(c) && rd_valid[c]) begin
        {out_start_v, out_start_h, out_end_v, out_end_h} = rd_data[c];
      end
    end
  end

endmodule

// File: tb/tb_lsd_multi_line_buffer.sv
// Directed self-checking bench for lsd_multi_line_buffer (2 channels, 16-deep banks).
module tb_lsd_multi_line_buffer;
  import lsd_multi_line_buffer_pkg::*;

  localparam int NCH = 2;
  localparam int HB  = 10;
  localparam int VB  = 9;
  localparam int DEP = 16;
  localparam int DB  = 8;
  localparam int AW  = 4;
  localparam int LW  = 5;

  logic              clock;
  logic              rst;
  logic [NCH-1:0]    in_flag;
  logic [NCH-1:0]    in_valid;
  logic [NCH*VB-1:0] in_start_v;
  logic [NCH*HB-1:0] in_start_h;
  logic [NCH*VB-1:0] in_end_v;
  logic [NCH*HB-1:0] in_end_h;
  logic              rd_ch;
  logic [AW-1:0]     rd_addr;
  logic              rd_release;
  logic [NCH-1:0]    out_ready;
  logic [NCH*LW-1:0] out_line_num;
  logic [NCH-1:0]    out_overflow;
  logic [NCH*DB-1:0] out_drop_cnt;
  logic [VB-1:0]     out_start_v;
  logic [HB-1:0]     out_start_h;
  logic [VB-1:0]     out_end_v;
  logic [HB-1:0]     out_end_h;

  int n_checks = 0;
  int n_errors = 0;

  lsd_multi_line_buffer #(
    .NUM_CH   (NCH),
    .H_BITW   (HB),
    .V_BITW   (VB),
    .DEPTH    (DEP),
    .DROP_BITW(DB)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .in_flag     (in_flag),
    .in_valid    (in_valid),
    .in_start_v  (in_start_v),
    .in_start_h  (in_start_h),
    .in_end_v    (in_end_v),
    .in_end_h    (in_end_h),
    .rd_ch       (rd_ch),
    .rd_addr     (rd_addr),
    .rd_release  (rd_release),
    .out_ready   (out_ready),
    .out_line_num(out_line_num),
    .out_overflow(out_overflow),
    .out_drop_cnt(out_drop_cnt),
    .out_start_v (out_start_v),
    .out_start_h (out_start_h),
    .out_end_v   (out_end_v),
    .out_end_h   (out_end_h)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Distinct, recognisable segment for (channel, frame, index).
  function automatic lsd_seg_t seg_val(input int ch, input int f, input int i);
    lsd_seg_t s;
    s.start_v = 9'(ch * 100 + f * 10 + i);
    s.start_h = 10'(ch * 200 + f * 20 + i + 1);
    s.end_v   = 9'(i * 3 + f);
    s.end_h   = 10'(1000 - i - f * 7);
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    in_valid   = '0;
    in_flag    = '0;
    rd_release = 1'b0;
  endtask

  task automatic set_seg(input int ch, input int f, input int i);
    lsd_seg_t s;
    s = seg_val(ch, f, i);
    in_valid[ch]             = 1'b1;
    in_start_v[ch*VB +: VB]  = s.start_v;
    in_start_h[ch*HB +: HB]  = s.start_h;
    in_end_v[ch*VB +: VB]    = s.end_v;
    in_end_h[ch*HB +: HB]    = s.end_h;
  endtask

  // n segments on channel ch, then a flag-only cycle.
  task automatic frame(input int ch, input int f, input int n);
    for (int i = 0; i < n; i++) begin
      set_seg(ch, f, i);
      tick();
      clr();
    end
    in_flag[ch] = 1'b1;
    tick();
    clr();
  endtask

  task automatic release_ch(input int ch);
    rd_ch      = 1'(ch);
    rd_release = 1'b1;
    tick();
    clr();
  endtask

  task automatic read_chk(input string tag, input int ch, input int addr, input logic [63:0] exp);
    rd_ch   = 1'(ch);
    rd_addr = AW'(addr);
    tick();
    check(tag, {out_start_v, out_start_h, out_end_v, out_end_h}, exp);
  endtask

  initial begin
    rst        = 1'b1;
    in_start_v = '0;
    in_start_h = '0;
    in_end_v   = '0;
    in_end_h   = '0;
    rd_ch      = 1'b0;
    rd_addr    = '0;
    clr();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", out_ready, 0);
    check("rst_line_num", out_line_num, 0);
    check("rst_overflow", out_overflow, 0);
    check("rst_drop", out_drop_cnt, 0);
    read_chk("rst_data", 0, 0, 0);

    // Basic capture and readback on ch0.
    frame(0, 1, 3);
    check("t1_ready", out_ready, 2'b01);
    check("t1_line_num", out_line_num[0 +: LW], 3);
    for (int i = 0; i < 3; i++) read_chk($sformatf("t1_rd%0d", i), 0, i, seg_val(0, 1, i));
    read_chk("t1_rd_past_end", 0, 3, 0);
    read_chk("t1_rd_ch1_not_ready", 1, 0, 0);
    release_ch(0);
    check("t1_released", out_ready, 2'b00);

    // Segment in the flag cycle belongs to the ending frame.
    for (int i = 0; i < 2; i++) begin
      set_seg(0, 2, i);
      tick();
      clr();
    end
    set_seg(0, 2, 2);
    in_flag[0] = 1'b1;
    tick();
    clr();
    check("t2_line_num", out_line_num[0 +: LW], 3);
    check("t2_ready", out_ready, 2'b01);
    read_chk("t2_rd2", 0, 2, seg_val(0, 2, 2));
    release_ch(0);

    // Overflow: DEPTH+5 segments, then a clean frame.
    frame(0, 3, DEP + 5);
    check("t3_line_num_full", out_line_num[0 +: LW], DEP);
    check("t3_overflow", out_overflow, 2'b01);
    read_chk("t3_rd_last", 0, DEP - 1, seg_val(0, 3, DEP - 1));
    release_ch(0);
    frame(0, 4, 2);
    check("t3_clean_overflow", out_overflow, 2'b00);
    check("t3_clean_line_num", out_line_num[0 +: LW], 2);
    release_ch(0);

    // Locked frame: two further frames are dropped, data stays.
    frame(0, 5, 4);
    frame(0, 6, 2);
    frame(0, 7, 1);
    check("t4_drop", out_drop_cnt[0 +: DB], 2);
    check("t4_line_num_kept", out_line_num[0 +: LW], 4);
    read_chk("t4_rd_kept", 0, 3, seg_val(0, 5, 3));
    release_ch(0);
    check("t4_released", out_ready, 2'b00);
    frame(0, 8, 3);
    check("t4_new_ready", out_ready, 2'b01);
    check("t4_new_line_num", out_line_num[0 +: LW], 3);
    read_chk("t4_new_rd0", 0, 0, seg_val(0, 8, 0));
    check("t4_drop_hold", out_drop_cnt[0 +: DB], 2);
    release_ch(0);

    // Release and frame end on ch1 in the same cycle.
    frame(1, 1, 2);
    check("t5_ready_first", out_ready, 2'b10);
    for (int i = 0; i < 3; i++) begin
      set_seg(1, 2, i);
      tick();
      clr();
    end
    set_seg(1, 2, 3);
    in_flag[1] = 1'b1;
    rd_ch      = 1'b1;
    rd_release = 1'b1;
    tick();
    clr();
    check("t5_ready_stays", out_ready, 2'b10);
    check("t5_line_num", out_line_num[LW +: LW], 4);
    check("t5_no_drop", out_drop_cnt[DB +: DB], 0);
    read_chk("t5_rd3", 1, 3, seg_val(1, 2, 3));
    read_chk("t5_rd1", 1, 1, seg_val(1, 2, 1));
    release_ch(1);

    // Simultaneous frame ends on both channels.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) set_seg(0, 9, i);
      set_seg(1, 3, i);
      tick();
      clr();
    end
    in_flag = 2'b11;
    tick();
    clr();
    check("t6_ready_both", out_ready, 2'b11);
    check("t6_line_nums", out_line_num, {5'd7, 5'd4});
    read_chk("t6_rd_ch0", 0, 3, seg_val(0, 9, 3));
    read_chk("t6_rd_ch1", 1, 6, seg_val(1, 3, 6));
    read_chk("t6_rd_ch0_past", 0, 4, 0);

    // Reset in the middle of a frame.
    set_seg(0, 10, 0);
    tick();
    set_seg(0, 10, 1);
    tick();
    clr();
    rst = 1'b1;
    tick();
    check("t6_rst_ready", out_ready, 0);
    check("t6_rst_line_num", out_line_num, 0);
    check("t6_rst_overflow", out_overflow, 0);
    check("t6_rst_drop", out_drop_cnt, 0);
    check("t6_rst_data", {out_start_v, out_start_h, out_end_v, out_end_h}, 0);
    rst = 1'b0;
    frame(0, 11, 1);
    check("t6_after_rst_ready", out_ready, 2'b01);
    check("t6_after_rst_line_num", out_line_num[0 +: LW], 1);
    read_chk("t6_after_rst_rd0", 0, 0, seg_val(0, 11, 0));
    read_chk("t6_after_rst_rd1", 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
